// File: rtl/output_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_pkg
// Description : Shared defaults, FSM state encoding and index-width helper
//               for the output-layer multiply-accumulate engine.
// Revision    : 1.0 - initial release
// ============================================================================
package output_layer_pkg;

    // Default geometry of the output layer
    localparam int N_IN_DEFAULT  = 30;   // hidden-layer width
    localparam int N_OUT_DEFAULT = 10;   // digit classes
    localparam int W_DEFAULT     = 8;    // weight / bias width
    localparam int ACT_W_DEFAULT = 8;    // activation width
    localparam int ACC_W_DEFAULT = 24;   // accumulator / score width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter able to index n elements (never narrower than 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : output_layer_pkg
`default_nettype wire

// File: rtl/signed_mac.sv
`default_nettype none
// ============================================================================
// Module      : signed_mac
// Description : Combinational signed multiply-accumulate.
//               o_sum = i_acc + sext(i_weight * i_act), modulo 2^ACC_W.
// Ports       : i_weight  W-bit signed weight
//               i_act     ACT_W-bit signed activation
//               i_acc     ACC_W-bit signed running sum
//               o_sum     ACC_W-bit signed result
// Revision    : 1.0 - initial release
// ============================================================================
module signed_mac #(
    parameter int W     = 8,
    parameter int ACT_W = 8,
    parameter int ACC_W = 24
) (
    input  logic signed [W-1:0]     i_weight,
    input  logic signed [ACT_W-1:0] i_act,
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [ACC_W-1:0] o_sum
);

    localparam int c_prod_w = W + ACT_W;

    logic signed [c_prod_w-1:0] w_prod;

    // Operands widened first so the product is formed at full precision
    assign w_prod = c_prod_w'(i_weight) * c_prod_w'(i_act);
    assign o_sum  = i_acc + ACC_W'(w_prod);

endmodule : signed_mac
`default_nettype wire

// File: rtl/output_layer_mac.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_mac
// Description : Sequential output-layer engine. One shared signed MAC walks
//               all N_OUT x N_IN products, writes each neuron's score as it
//               completes and tracks the argmax on the fly.
// Ports       : clk, rst           clock, synchronous active-high reset
//               start              request inference (accepted in IDLE only)
//               act_in             N_IN activations, latched on start
//               weights_HL         weight (i,j) at [(i*N_IN+j)*W +: W]
//               biases_HL          bias i at [i*W +: W]
//               busy               high while the MAC walk is in progress
//               done               one-cycle pulse when results are valid
//               scores             score i at [i*ACC_W +: ACC_W]
//               digit              index of the highest score
// Revision    : 1.0 - initial release
// ============================================================================
module output_layer_mac
    import output_layer_pkg::*;
#(
    parameter int N_IN       = N_IN_DEFAULT,
    parameter int N_OUT      = N_OUT_DEFAULT,
    parameter int W          = W_DEFAULT,
    parameter int ACT_W      = ACT_W_DEFAULT,
    parameter int ACC_W      = ACC_W_DEFAULT,
    parameter int BIAS_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ACT_W*N_IN-1:0]    act_in,
    input  logic [W*N_OUT*N_IN-1:0]  weights_HL,
    input  logic [W*N_OUT-1:0]       biases_HL,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W*N_OUT-1:0]   scores,
    output logic [3:0]               digit
);

    localparam int c_i_w   = idx_width(N_OUT);
    localparam int c_j_w   = idx_width(N_IN);
    localparam int c_idx_w = idx_width(N_OUT * N_IN);

    state_t                  r_state;
    logic [c_i_w-1:0]        r_i;
    logic [c_j_w-1:0]        r_j;
    logic [ACT_W*N_IN-1:0]   r_act;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_best;
    logic [ACC_W*N_OUT-1:0]  r_scores;
    logic [3:0]              r_digit;
    logic                    r_busy;
    logic                    r_done;

    logic [c_idx_w-1:0]      w_widx;
    logic signed [W-1:0]     w_weight;
    logic signed [ACT_W-1:0] w_act;
    logic [c_i_w-1:0]        w_bias_idx;
    logic signed [W-1:0]     w_bias;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_last_j;
    logic                    w_last_i;

    assign w_last_j = (r_j == c_j_w'(N_IN - 1));
    assign w_last_i = (r_i == c_i_w'(N_OUT - 1));

    assign w_widx   = c_idx_w'(r_i) * c_idx_w'(N_IN) + c_idx_w'(r_j);
    assign w_weight = weights_HL[w_widx*W +: W];
    assign w_act    = r_act[r_j*ACT_W +: ACT_W];

    // The bias being loaded is always that of the neuron about to start:
    // neuron 0 when leaving IDLE, otherwise i+1. Clamped on the last neuron
    // so the select never leaves the bus.
    assign w_bias_idx = (r_state == ST_IDLE || w_last_i) ? '0 : r_i + c_i_w'(1);
    assign w_bias     = biases_HL[w_bias_idx*W +: W];
    assign w_bias_ext = ACC_W'(w_bias) <<< BIAS_SHIFT;

    signed_mac #(
        .W     (W),
        .ACT_W (ACT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_weight (w_weight),
        .i_act    (w_act),
        .i_acc    (r_acc),
        .o_sum    (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_act    <= '0;
            r_acc    <= '0;
            r_best   <= '0;
            r_scores <= '0;
            r_digit  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_act   <= act_in;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_acc   <= w_bias_ext;
                        r_busy  <= 1'b1;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (!w_last_j) begin
                        r_acc <= w_sum;
                        r_j   <= r_j + c_j_w'(1);
                    end else begin
                        r_scores[r_i*ACC_W +: ACC_W] <= w_sum;
                        // Strict compare: equal scores keep the lower index
                        if (r_i == '0 || w_sum > r_best) begin
                            r_best  <= w_sum;
                            r_digit <= 4'(r_i);
                        end
                        if (!w_last_i) begin
                            r_i   <= r_i + c_i_w'(1);
                            r_j   <= '0;
                            r_acc <= w_bias_ext;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign scores = r_scores;
    assign digit  = r_digit;

endmodule : output_layer_mac
`default_nettype wire
